// File: rtl/pc_sequencer_if.sv
//==============================================================================
// pc_sequencer_if : control/status bundle between a host and pc_sequencer
// Rev 1.0
//==============================================================================
`default_nettype none

interface pc_sequencer_if #(
  parameter int ADDR_MAX  = 16,
  parameter int OFF_W     = 12,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic                enable;
  logic [2:0]          op;
  logic                cond;
  logic [OFF_W-1:0]    offset;
  logic [ADDR_MAX-1:0] target;
  logic [ADDR_MAX-1:0] pc;
  logic [CNT_W-1:0]    ras_count;
  logic                ras_full;
  logic                ras_empty;
  logic                ras_err;

  modport master (
    output enable, op, cond, offset, target,
    input  pc, ras_count, ras_full, ras_empty, ras_err
  );

  modport slave (
    input  enable, op, cond, offset, target,
    output pc, ras_count, ras_full, ras_empty, ras_err
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
//==============================================================================
// pc_sequencer : program counter with relative/absolute branches and a RAS
// Rev 1.0
//==============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int ADDR_MAX  = 16,
  parameter int OFF_W     = 12,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_VEC = 0
) (
  input  logic             clk,
  input  logic             rst,
  pc_sequencer_if.slave    bus
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_BR   = 3'd1;
  localparam logic [2:0] OP_BRC  = 3'd2;
  localparam logic [2:0] OP_JMP  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;

  localparam logic [ADDR_MAX-1:0] RESET_PC = ADDR_MAX'(RESET_VEC);

  logic [ADDR_MAX-1:0] pc_q;
  logic [CNT_W-1:0]    count;
  logic                err;
  // Entry 0 is the top of stack; a push shifts everything down one slot so
  // the oldest entry falls off the end when the stack is already full.
  logic [ADDR_MAX-1:0] stack [RAS_DEPTH];

  logic signed [OFF_W-1:0] off_s;
  logic [ADDR_MAX-1:0]     seq_pc;
  logic [ADDR_MAX-1:0]     br_pc;
  logic                    is_full;
  logic                    is_empty;

  assign off_s    = bus.offset;
  assign seq_pc   = pc_q + ADDR_MAX'(1);
  assign br_pc    = pc_q + ADDR_MAX'(off_s);
  assign is_full  = (count == CNT_W'(RAS_DEPTH));
  assign is_empty = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      count <= '0;
      err   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else if (bus.enable) begin
      case (bus.op)
        OP_SEQ: pc_q <= seq_pc;
        OP_BR:  pc_q <= br_pc;
        OP_BRC: pc_q <= bus.cond ? br_pc : seq_pc;
        OP_JMP: pc_q <= bus.target;
        OP_CALL: begin
          pc_q     <= bus.target;
          stack[0] <= seq_pc;
          for (int i = 1; i < RAS_DEPTH; i++) begin
            stack[i] <= stack[i-1];
          end
          if (is_full) begin
            err <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        OP_RET: begin
          if (is_empty) begin
            pc_q <= seq_pc;
            err  <= 1'b1;
          end else begin
            pc_q <= stack[0];
            for (int i = 0; i < RAS_DEPTH - 1; i++) begin
              stack[i] <= stack[i+1];
            end
            stack[RAS_DEPTH-1] <= '0;
            count <= count - CNT_W'(1);
          end
        end
        default: pc_q <= seq_pc;
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.ras_count = count;
  assign bus.ras_full  = is_full;
  assign bus.ras_empty = is_empty;
  assign bus.ras_err   = err;

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL provide parameter ADDR_MAX, default 16, PC and target width in bits.
REQ-002 SHALL provide parameter OFF_W, default 12, relative-branch offset width (OFF_W <= ADDR_MAX).
REQ-003 SHALL provide parameter RAS_DEPTH, default 4, return-address-stack entries (>= 2).
REQ-004 SHALL provide parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-005 SHALL provide: clock  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL provide: reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL provide: enable  in  1  1 = execute op this cycle; 0 = hold all state.
REQ-008 SHALL provide: op  in  3  operation select (see REQ-012).
REQ-009 SHALL provide: cond  in  1  condition for conditional branch.
REQ-010 SHALL provide: offset  in  OFF_W  two's-complement relative offset; target  in  ADDR_MAX  absolute jump/call address.
REQ-011 SHALL provide outputs: pc  ADDR_MAX  current PC (registered); ras_count  clog2(RAS_DEPTH+1)  stack occupancy; ras_full  1; ras_empty  1; ras_err  1  sticky overflow/underflow flag.

Function
REQ-012 SHALL decode op when enable=1: 000 SEQ pc<=pc+1; 001 BR pc<=pc+sext(offset); 010 BRC pc<=cond ? pc+sext(offset) : pc+1; 011 JMP pc<=target; 100 CALL push pc+1, pc<=target; 101 RET pop, pc<=popped value; 110/111 reserved, behave as SEQ, no flag change.
REQ-013 SHALL sign-extend offset from bit OFF_W-1 to ADDR_MAX bits before addition.
REQ-014 SHALL compute all PC arithmetic modulo 2^ADDR_MAX (pc=all-ones + 1 -> 0; negative offsets wrap below 0).
REQ-015 SHALL apply the new pc value on the same rising edge that samples enable=1; latency one cycle, no bubbles.
REQ-016 SHALL, when enable=0, hold pc, stack contents, ras_count and ras_err regardless of op, cond, offset, target.
REQ-017 SHALL implement the stack as LIFO; RET returns the most recently pushed, not-yet-popped value.
REQ-018 SHALL on CALL with stack full: discard the oldest entry, push pc+1, keep ras_count=RAS_DEPTH, set ras_err.
REQ-019 SHALL on RET with stack empty: pc<=pc+1, ras_count stays 0, set ras_err.
REQ-020 SHALL keep ras_err set until reset; no other clear path.
REQ-021 SHALL drive ras_full = (ras_count==RAS_DEPTH) and ras_empty = (ras_count==0), derived from registered count, valid same cycle as pc.
REQ-022 SHALL store return addresses full ADDR_MAX width; a pushed all-ones+1 value wraps to 0 before storage.

Reset
REQ-023 SHALL on reset=1, asynchronously and independent of clock/enable: pc=RESET_VEC, ras_count=0, ras_empty=1, ras_full=0, ras_err=0, all stack entries=0.
REQ-024 SHALL hold reset values while reset=1; first op executes on first rising edge with reset=0 and enable=1.
REQ-025 SHALL abandon any in-progress CALL/RET sequence on reset mid-operation; stack contents not retained.

Verification
REQ-026 Reset then 3 cycles SEQ, enable=1 -> pc 0,1,2,3; ras_empty=1, ras_err=0.
REQ-027 pc=0x0010, BR offset=0xFFC (-4) -> pc=0x000C; BRC cond=0 offset=0x005 -> pc=0x000D; BRC cond=1 offset=0x005 -> pc=0x0012.
REQ-028 pc=0x0100, CALL target=0x0200 -> pc=0x0200, ras_count=1; CALL target=0x0300 -> ras_count=2; RET -> pc=0x0201; RET -> pc=0x0101, ras_empty=1.
REQ-029 Five CALLs from pc=0x10,0x20,0x30,0x40,0x50 (RAS_DEPTH=4) -> ras_full=1, ras_err=1; four RETs return 0x51,0x41,0x31,0x21; fifth RET -> pc+1, ras_err stays 1.
REQ-030 pc=0xFFFF, SEQ -> pc=0x0000; enable=0 with op=JMP target=0x1234 -> pc unchanged.
REQ-031 Assert reset between clock edges after two CALLs -> pc=RESET_VEC, ras_count=0, ras_err=0 immediately, before next edge.
